// File: rtl/alu_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_pkg
// Description : Shared constants for the ALU operand stage: operand-select
//               encodings and the register-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_operand_stage_pkg;

    // Architectural register index width (x0..x31)
    localparam int c_REG_IDX_W = 5;

    // Operand A select encodings (2'b11 is a legal alias of zero)
    localparam logic [1:0] c_A_SEL_RS1  = 2'b00;
    localparam logic [1:0] c_A_SEL_ZERO = 2'b01;
    localparam logic [1:0] c_A_SEL_PC   = 2'b10;
    localparam logic [1:0] c_A_SEL_ZALT = 2'b11;

    // Operand B select encodings (2'b11 is a legal alias of imm)
    localparam logic [1:0] c_B_SEL_RS2    = 2'b00;
    localparam logic [1:0] c_B_SEL_IMM    = 2'b01;
    localparam logic [1:0] c_B_SEL_IMM_S1 = 2'b10;
    localparam logic [1:0] c_B_SEL_IALT   = 2'b11;

endpackage : alu_operand_stage_pkg
`default_nettype wire

// File: rtl/alu_operand_stage_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Priority forwarding selector for one source register.
//               Source 0 is the youngest and wins over older sources.
//               x0 is never forwarded. Reports a load-use hazard when the
//               winning source is still pending and the register is used.
// Ports       : addr/use_reg/rdata  - source index, use flag, regfile data
//               fwd_valid/fwd_pending/fwd_rd/fwd_data - packed forward sources
//               data/hazard         - selected operand, load-use hazard
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic [c_REG_IDX_W-1:0]         addr,
    input  logic                           use_reg,
    input  logic [XLEN-1:0]                rdata,
    input  logic [NUM_FWD-1:0]             fwd_valid,
    input  logic [NUM_FWD-1:0]             fwd_pending,
    input  logic [c_REG_IDX_W*NUM_FWD-1:0] fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0]        fwd_data,
    output logic [XLEN-1:0]                data,
    output logic                           hazard
);

    logic w_found;

    always_comb begin
        data    = rdata;
        hazard  = 1'b0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            // First match wins; older matches are shadowed, including their
            // pending state.
            if (!w_found && fwd_valid[i] && (addr != '0) &&
                (fwd_rd[i*c_REG_IDX_W +: c_REG_IDX_W] == addr)) begin
                w_found = 1'b1;
                data    = fwd_data[i*XLEN +: XLEN];
                hazard  = use_reg && fwd_pending[i];
            end
        end
    end

endmodule : fwd_select
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Registered ALU operand stage between decode and execute.
//               Forwards rs1/rs2, muxes operands A/B, stalls on load-use
//               hazards and holds the result in a one-entry valid/ready
//               register with flush.
// Ports       : in_valid/in_ready   - decode handshake
//               rs*_addr/use_rs*/rdata*, pc, imm, a_sel, b_sel - operands
//               fwd_*               - forwarding sources (index 0 youngest)
//               flush               - drop held entry and current input
//               out_valid/out_ready - execute handshake
//               alu_a/alu_b/store_data - registered operands
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_FWD  = 2,
    parameter int PC_SHIFT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [c_REG_IDX_W-1:0]         rs1_addr,
    input  logic [c_REG_IDX_W-1:0]         rs2_addr,
    input  logic                           use_rs1,
    input  logic                           use_rs2,
    input  logic [XLEN-1:0]                rdata1,
    input  logic [XLEN-1:0]                rdata2,
    input  logic [XLEN-1:0]                pc,
    input  logic [XLEN-1:0]                imm,
    input  logic [1:0]                     a_sel,
    input  logic [1:0]                     b_sel,
    input  logic [NUM_FWD-1:0]             fwd_valid,
    input  logic [NUM_FWD-1:0]             fwd_pending,
    input  logic [c_REG_IDX_W*NUM_FWD-1:0] fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0]        fwd_data,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [XLEN-1:0]                alu_a,
    output logic [XLEN-1:0]                alu_b,
    output logic [XLEN-1:0]                store_data
);

    logic [XLEN-1:0] w_rs1_val, w_rs2_val;
    logic            w_rs1_haz, w_rs2_haz;
    logic [XLEN-1:0] w_op_a, w_op_b;
    logic            w_accept;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [XLEN-1:0] store_data_q, store_data_d;

    fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
        .addr        (rs1_addr),
        .use_reg     (use_rs1),
        .rdata       (rdata1),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .data        (w_rs1_val),
        .hazard      (w_rs1_haz)
    );

    fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
        .addr        (rs2_addr),
        .use_reg     (use_rs2),
        .rdata       (rdata2),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .data        (w_rs2_val),
        .hazard      (w_rs2_haz)
    );

    always_comb begin
        w_op_a = '0;
        case (a_sel)
            c_A_SEL_RS1: w_op_a = w_rs1_val;
            c_A_SEL_PC:  w_op_a = pc << PC_SHIFT;
            default:     w_op_a = '0;
        endcase
    end

    always_comb begin
        w_op_b = imm;
        case (b_sel)
            c_B_SEL_RS2:    w_op_b = w_rs2_val;
            c_B_SEL_IMM_S1: w_op_b = imm << 1;
            default:        w_op_b = imm;
        endcase
    end

    // Ready ignores in_valid so decode can use it without a combinational loop.
    assign in_ready = !(w_rs1_haz || w_rs2_haz) && (!out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        store_data_d = store_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d  = 1'b1;
            alu_a_d      = w_op_a;
            alu_b_d      = w_op_b;
            store_data_d = w_rs2_val;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            store_data_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            store_data_q <= store_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign store_data = store_data_q;

endmodule : alu_operand_stage
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Self-checking bench for alu_operand_stage with a behavioural
//               reference model of forwarding, hazards and the output entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    localparam int XLEN     = 32;
    localparam int NUM_FWD  = 2;
    localparam int PC_SHIFT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [4:0]        rs1_addr, rs2_addr;
    logic              use_rs1, use_rs2;
    logic [XLEN-1:0]   rdata1, rdata2, pc, imm;
    logic [1:0]        a_sel, b_sel;
    logic [NUM_FWD-1:0] fwd_valid, fwd_pending;
    logic [5*NUM_FWD-1:0]    fwd_rd;
    logic [XLEN*NUM_FWD-1:0] fwd_data;
    logic              flush, out_valid, out_ready;
    logic [XLEN-1:0]   alu_a, alu_b, store_data;

    // Forward sources kept as arrays; packed for the DUT below
    logic [4:0]      t_rd   [NUM_FWD];
    logic [XLEN-1:0] t_data [NUM_FWD];

    always_comb begin
        fwd_rd   = '0;
        fwd_data = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            fwd_rd[i*5 +: 5]       = t_rd[i];
            fwd_data[i*XLEN +: XLEN] = t_data[i];
        end
    end

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .PC_SHIFT(PC_SHIFT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rdata1(rdata1), .rdata2(rdata2), .pc(pc), .imm(imm), .a_sel(a_sel), .b_sel(b_sel),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic            m_valid;
    logic [XLEN-1:0] m_a, m_b, m_sd;

    // Value of a register as seen at the operand stage: the youngest valid
    // writer wins; scanning oldest-to-youngest lets younger ones overwrite.
    function automatic logic [XLEN-1:0] ref_src(input logic [4:0] a, input logic [XLEN-1:0] rd);
        logic [XLEN-1:0] v;
        v = rd;
        if (a != 5'd0)
            for (int i = NUM_FWD - 1; i >= 0; i--)
                if (fwd_valid[i] && t_rd[i] == a) v = t_data[i];
        return v;
    endfunction

    function automatic logic ref_haz(input logic [4:0] a, input logic u);
        logic p;
        p = 1'b0;
        if (a != 5'd0)
            for (int i = NUM_FWD - 1; i >= 0; i--)
                if (fwd_valid[i] && t_rd[i] == a) p = fwd_pending[i];
        return u && p;
    endfunction

    function automatic logic ref_ready();
        return !(ref_haz(rs1_addr, use_rs1) || ref_haz(rs2_addr, use_rs2)) &&
               (!m_valid || out_ready);
    endfunction

    // Advance the model by one clock using the current inputs, then clock.
    task automatic step();
        logic acc;
        acc = in_valid && ref_ready() && !flush;
        if (flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            case (a_sel)
                2'b00:   m_a = ref_src(rs1_addr, rdata1);
                2'b10:   m_a = XLEN'(pc * (2 ** PC_SHIFT));
                default: m_a = '0;
            endcase
            case (b_sel)
                2'b00:   m_b = ref_src(rs2_addr, rdata2);
                2'b10:   m_b = XLEN'(imm * 2);
                default: m_b = imm;
            endcase
            m_sd = ref_src(rs2_addr, rdata2);
        end else if (out_ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; rs1_addr = 0; rs2_addr = 0; use_rs1 = 0; use_rs2 = 0;
        rdata1 = 0; rdata2 = 0; pc = 0; imm = 0; a_sel = 0; b_sel = 0;
        fwd_valid = 0; fwd_pending = 0; flush = 0; out_ready = 1;
        for (int i = 0; i < NUM_FWD; i++) begin t_rd[i] = 0; t_data[i] = 0; end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; m_valid = 0; m_a = 0; m_b = 0; m_sd = 0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if ({alu_a, alu_b, store_data} !== '0) begin failures++; $display("FAIL reset_data got=%h %h %h exp=0", alu_a, alu_b, store_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        idle_inputs();
        in_valid = 1; rdata1 = 5; rdata2 = 7;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || store_data !== 32'd7) begin
            failures++; $display("FAIL basic_data got=%0d %0d %0d exp=5 7 7", alu_a, alu_b, store_data); end
        step();
    endtask

    task automatic test_pc_imm();
        idle_inputs();
        in_valid = 1; pc = 32'h10; a_sel = 2'b10; imm = 32'hFFFF_FFFC; b_sel = 2'b10;
        step();
        in_valid = 0;
        checks++; if (alu_a !== 32'h40 || alu_b !== 32'hFFFF_FFF8 || out_valid !== 1'b1) begin
            failures++; $display("FAIL pc_imm got=%h %h v=%0b exp=00000040 fffffff8 v=1", alu_a, alu_b, out_valid); end
        step();
    endtask

    task automatic test_forward_priority();
        idle_inputs();
        in_valid = 1; rs1_addr = 3; use_rs1 = 1; rdata1 = 32'h55;
        fwd_valid = 2'b11; t_rd[0] = 3; t_rd[1] = 3; t_data[0] = 32'hAA; t_data[1] = 32'hBB;
        step();
        checks++; if (alu_a !== 32'hAA) begin failures++; $display("FAIL fwd_prio got=%h exp=000000aa", alu_a); end
        rs1_addr = 0; t_rd[0] = 0; t_rd[1] = 0;
        step();
        in_valid = 0;
        checks++; if (alu_a !== 32'h55) begin failures++; $display("FAIL fwd_x0 got=%h exp=00000055", alu_a); end
        step();
    endtask

    task automatic test_hazard();
        idle_inputs();
        in_valid = 1; rs2_addr = 4; use_rs2 = 1; rdata2 = 32'h9;
        fwd_valid = 2'b01; fwd_pending = 2'b01; t_rd[0] = 4;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hazard_ready got=%0b exp=0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hazard_stall got=%0b exp=0", out_valid); end
        // Younger non-pending match shadows the older pending one
        fwd_valid = 2'b11; fwd_pending = 2'b10; t_rd[1] = 4; t_data[0] = 32'h1234;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hazard_release got=%0b exp=1", in_ready); end
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || alu_b !== 32'h1234 || store_data !== 32'h1234) begin
            failures++; $display("FAIL hazard_fwd got v=%0b %h %h exp v=1 00001234", out_valid, alu_b, store_data); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] sa, sb;
        idle_inputs();
        out_ready = 0; in_valid = 1; rdata1 = 32'h11; rdata2 = 32'h22;
        step();
        sa = alu_a; sb = alu_b;
        rdata1 = 32'h33; rdata2 = 32'h44;
        for (int k = 0; k < 3; k++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready cyc=%0d got=%0b exp=0", k, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || alu_a !== sa || alu_b !== sb || sa !== 32'h11) begin
                failures++; $display("FAIL hold_stable cyc=%0d got %h %h exp 00000011 %h", k, alu_a, alu_b, sb); end
        end
        out_ready = 1;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || alu_a !== 32'h33 || alu_b !== 32'h44) begin
            failures++; $display("FAIL b2b got v=%0b %h %h exp v=1 00000033 00000044", out_valid, alu_a, alu_b); end
        step();
    endtask

    task automatic test_flush();
        idle_inputs();
        out_ready = 0; in_valid = 1; rdata1 = 1;
        step();
        in_valid = 0; flush = 1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_hold got=%0b exp=0", out_valid); end
        in_valid = 1; out_ready = 1;
        step();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_input got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_hold();
        idle_inputs();
        out_ready = 0; in_valid = 1; rdata1 = 32'hDEAD; rdata2 = 32'hBEEF;
        step();
        in_valid = 0;
        step();
        #2 rst = 1;
        m_valid = 0; m_a = 0; m_b = 0; m_sd = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || {alu_a, alu_b, store_data} !== '0) begin
            failures++; $display("FAIL rst_mid_hold got v=%0b %h %h %h exp all 0", out_valid, alu_a, alu_b, store_data); end
        @(negedge clk); rst = 0; out_ready = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 300; n++) begin
            in_valid = $urandom_range(0, 3) != 0;
            rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
            use_rs1 = 1'($urandom); use_rs2 = 1'($urandom);
            rdata1 = $urandom; rdata2 = $urandom; pc = $urandom; imm = $urandom;
            a_sel = 2'($urandom); b_sel = 2'($urandom);
            fwd_valid = NUM_FWD'($urandom); fwd_pending = NUM_FWD'($urandom_range(0, 3) == 0 ? $urandom : 0);
            for (int i = 0; i < NUM_FWD; i++) begin t_rd[i] = 5'($urandom_range(0, 3)); t_data[i] = $urandom; end
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            #1;
            checks++; if (in_ready !== ref_ready()) begin failures++; $display("FAIL rand_ready n=%0d got=%0b exp=%0b", n, in_ready, ref_ready()); end
            step();
            checks++; if (out_valid !== m_valid) begin failures++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (alu_a !== m_a || alu_b !== m_b || store_data !== m_sd) begin
                    failures++; $display("FAIL rand_data n=%0d got %h %h %h exp %h %h %h", n, alu_a, alu_b, store_data, m_a, m_b, m_sd); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pc_imm();
        test_forward_priority();
        test_hazard();
        test_back_to_back();
        test_flush();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_operand_stage
`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered ALU operand stage between decode and execute. Selects ALU operand A/B from register data, PC, immediate or zero, applies operand forwarding from up to `NUM_FWD` later pipeline stages, and detects load-use hazards. Holds results in a one-entry valid/ready pipeline register with flush support. Generalises the combinational operand mux with parametrised width, PC scaling, forwarding depth and backpressure.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NUM_FWD`, 2, forwarding sources; index 0 is youngest and has highest priority.
- `PC_SHIFT`, 2, left shift applied to `pc` when it is selected as operand A (word-index PC).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `rs1_addr`, `rs2_addr`  in  5  source register indices.
- `use_rs1`, `use_rs2`  in  1  instruction reads rs1/rs2 (hazard qualifier).
- `rdata1`, `rdata2`  in  XLEN  register-file read data.
- `pc`  in  XLEN  instruction PC.
- `imm`  in  XLEN  sign-extended immediate.
- `a_sel`  in  2  00 rs1, 01 zero, 10 pc<<PC_SHIFT, 11 zero.
- `b_sel`  in  2  00 rs2, 01 imm, 10 imm<<1, 11 imm.
- `fwd_valid`  in  NUM_FWD  source i writes a register.
- `fwd_pending`  in  NUM_FWD  source i result is not yet available (load in flight).
- `fwd_rd`  in  5*NUM_FWD  destination index of source i, slice [5i+4:5i].
- `fwd_data`  in  XLEN*NUM_FWD  result of source i, slice [XLEN*i+XLEN-1:XLEN*i].
- `flush`  in  1  discard the held entry and the input this cycle.
- `out_valid`  out  1  registered operands valid.
- `out_ready`  in  1  execute consumes this cycle.
- `alu_a`, `alu_b`  out  XLEN  registered operands.
- `store_data`  out  XLEN  registered forwarded rs2, for stores.

## Operation
- Forwarded rsN: find the lowest i with `fwd_valid[i]`, `fwd_rd[i]==rsN_addr` and `rsN_addr!=0`. If found, use `fwd_data[i]`; otherwise use `rdataN`. x0 always reads register data, never forwarded data.
- Hazard: `use_rsN` is set, and the matching source found above has `fwd_pending[i]` set. A pending entry that is shadowed by a younger non-pending match is not a hazard.
- `in_ready = !hazard && (!out_valid || out_ready)`. This is combinational and does not depend on `in_valid`.
- Accept means `in_valid && in_ready && !flush`. On accept, register alu_a/alu_b/store_data and set `out_valid`.
- Consume without accept: clear `out_valid`.
- Consume and accept in the same cycle: load the new entry, `out_valid` stays 1.
- Held entry (`out_valid && !out_ready`): registered outputs are stable and `in_ready`=0.
- `flush` takes priority over accept and hold: `out_valid` is 0 next cycle and the data registers are don't-care.
- Shifts are logical left, truncated to XLEN. The `a_sel`=11 and `b_sel`=11 encodings are legal aliases.

## Timing
- Reset: `out_valid`=0 and `alu_a`=`alu_b`=`store_data`=0, applied asynchronously. `in_ready`=1 during reset unless a hazard is present.
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 per cycle when `out_ready` is held high.
- Forward and hazard evaluation is combinational on the accept cycle. Forward inputs are sampled only at accept and are not tracked while an entry is held.
- A reset asserted mid-hold drops the entry. There is no replay.

## Structure
- Shared package holds the `a_sel`/`b_sel` encoding constants and the register-index width constant (5).
- One sub-module, `fwd_select`, instantiated twice (rs1 and rs2). Inputs: address, use flag, register data, forward vectors. Outputs: data and hazard. It is a priority loop over `NUM_FWD`.
- The top level contains the operand muxes, the ready logic and the pipeline register.

## Test plan
- rdata1=5, rdata2=7, a_sel=00, b_sel=00, no forwards, out_ready=1 → next cycle alu_a=5, alu_b=7, store_data=7, out_valid=1.
- pc=0x10, a_sel=10, imm=0xFFFFFFFC, b_sel=10 → alu_a=0x40, alu_b=0xFFFFFFF8.
- rs1=3, fwd_valid=2'b11, fwd_rd={3,3}, fwd_data={0xBB,0xAA} (index 0 = 0xAA) → alu_a=0xAA. Same stimulus with rs1=0 → alu_a=rdata1.
- rs2=4, use_rs2=1, fwd_pending[0]=1, fwd_rd[0]=4 → in_ready=0 and out_valid stays 0. Drop pending and present the data → accepted, alu_b equals the forwarded value.
- Entry held with out_ready=0 for 3 cycles → outputs constant and in_ready=0. Then out_ready=1 with a new in_valid → back-to-back update, out_valid stays 1.
- flush while holding, and separately while in_valid=1 → out_valid=0 next cycle. rst asserted mid-hold → out_valid=0 immediately and outputs reset to 0.
